regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 97 +++++++++
 tb/tb_regfile_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between the ALU writeback
// stage (requester 0) and the multi-cycle/load unit (requester 1).
// Round-robin priority on contention; the winning request is registered
// onto WriteEnable/WriteSelect/WriteData and acknowledged for one cycle.
module regfile_write_arbiter #(
    parameter int unsigned REG_SELECT_WIDTH = 5,
    parameter int unsigned DATA_WIDTH       = 32
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Req0,
    input  logic [REG_SELECT_WIDTH-1:0] Sel0,
    input  logic [DATA_WIDTH-1:0]       Data0,
    input  logic                        Req1,
    input  logic [REG_SELECT_WIDTH-1:0] Sel1,
    input  logic [DATA_WIDTH-1:0]       Data1,
    output logic                        Ack0,
    output logic                        Ack1,
    output logic                        WriteEnable,
    output logic [REG_SELECT_WIDTH-1:0] WriteSelect,
    output logic [DATA_WIDTH-1:0]       WriteData
);

    typedef enum logic {
        GRANT_0 = 1'b0,
        GRANT_1 = 1'b1
    } grant_t;

    grant_t                        last_grant_q, last_grant_d;
    logic                          we_q, we_d;
    logic                          ack0_q, ack0_d;
    logic                          ack1_q, ack1_d;
    logic [REG_SELECT_WIDTH-1:0]   sel_q, sel_d;
    logic [DATA_WIDTH-1:0]         data_q, data_d;

    logic                          elig0, elig1;
    logic                          grant0, grant1;

    // Eligibility masks a request already acknowledged this cycle so a held
    // request is written exactly once; ties go to the requester not granted last.
    always_comb begin
        elig0  = Req0 & ~ack0_q;
        elig1  = Req1 & ~ack1_q;
        grant0 = elig0 & (~elig1 | (last_grant_q == GRANT_1));
        grant1 = elig1 & ~grant0;
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        we_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        sel_d        = sel_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        if (grant0) begin
            we_d         = 1'b1;
            ack0_d       = 1'b1;
            sel_d        = Sel0;
            data_d       = Data0;
            last_grant_d = GRANT_0;
        end else if (grant1) begin
            we_d         = 1'b1;
            ack1_d       = 1'b1;
            sel_d        = Sel1;
            data_d       = Data1;
            last_grant_d = GRANT_1;
        end
    end

    // State register; reset wins over any grant in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            we_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            sel_q        <= '0;
            data_q       <= '0;
            last_grant_q <= GRANT_1;
        end else begin
            we_q         <= we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign Ack0        = ack0_q;
    assign Ack1        = ack1_q;
    assign WriteEnable = we_q;
    assign WriteSelect = sel_q;
    assign WriteData   = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model and a
// register-file model written from the arbiter's outputs.
module tb_regfile_write_arbiter;

    localparam int SW = 5;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req0, Req1;
    logic [SW-1:0] Sel0, Sel1;
    logic [DW-1:0] Data0, Data1;
    logic          Ack0, Ack1, WriteEnable;
    logic [SW-1:0] WriteSelect;
    logic [DW-1:0] WriteData;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the output register and round-robin pointer.
    logic          m_we, m_ack0, m_ack1;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_data;
    int            m_last;

    // Register file model written from the arbiter's outputs at each edge.
    logic [DW-1:0] rf [32];

    regfile_write_arbiter #(
        .REG_SELECT_WIDTH(SW),
        .DATA_WIDTH      (DW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0       (Req0),
        .Sel0       (Sel0),
        .Data0      (Data0),
        .Req1       (Req1),
        .Sel1       (Sel1),
        .Data1      (Data1),
        .Ack0       (Ack0),
        .Ack1       (Ack1),
        .WriteEnable(WriteEnable),
        .WriteSelect(WriteSelect),
        .WriteData  (WriteData)
    );

    always #5 Clk = ~Clk;

    // Advance one cycle: compute the model's next state from the current
    // inputs, let the edge happen, then settle 1 time unit after it.
    task automatic tick();
        bit            e0, e1;
        int            g;
        logic          pwe;
        logic [SW-1:0] psel;
        logic [DW-1:0] pdata;
        e0 = Req0 && !m_ack0;
        e1 = Req1 && !m_ack1;
        if (e0 && e1)  g = 1 - m_last;
        else if (e0)   g = 0;
        else if (e1)   g = 1;
        else           g = -1;
        pwe   = WriteEnable;
        psel  = WriteSelect;
        pdata = WriteData;
        @(posedge Clk);
        if (pwe === 1'b1) rf[psel] = pdata;
        if (Reset) begin
            m_we = 0; m_ack0 = 0; m_ack1 = 0; m_sel = '0; m_data = '0; m_last = 1;
        end else if (g < 0) begin
            m_we = 0; m_ack0 = 0; m_ack1 = 0;
        end else begin
            m_we   = 1;
            m_ack0 = (g == 0);
            m_ack1 = (g == 1);
            m_sel  = (g == 0) ? Sel0 : Sel1;
            m_data = (g == 0) ? Data0 : Data1;
            m_last = g;
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1; Req0 = 1; Req1 = 1;
        Sel0 = 5'd1; Data0 = 32'h0000_0101; Sel1 = 5'd2; Data1 = 32'h0000_0202;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({WriteEnable, Ack0, Ack1, WriteSelect, WriteData} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got we=%b a0=%b a1=%b sel=%0d data=%h, want all zero",
                         i, WriteEnable, Ack0, Ack1, WriteSelect, WriteData);
            end
        end
        Reset = 0;
        tick();
        checks++;
        if (!(Ack0 === 1'b1 && Ack1 === 1'b0 && WriteEnable === 1'b1 && WriteSelect === 5'd1)) begin
            failures++;
            $display("FAIL reset_first_tie: got a0=%b a1=%b we=%b sel=%0d, want a0=1 a1=0 we=1 sel=1",
                     Ack0, Ack1, WriteEnable, WriteSelect);
        end
        tick();
        checks++;
        if (!(Ack1 === 1'b1 && Ack0 === 1'b0 && WriteSelect === 5'd2 && WriteData === 32'h0000_0202)) begin
            failures++;
            $display("FAIL reset_second_grant: got a0=%b a1=%b sel=%0d data=%h, want a0=0 a1=1 sel=2 data=00000202",
                     Ack0, Ack1, WriteSelect, WriteData);
        end
        Req0 = 0; Req1 = 0;
        tick();
    endtask

    task automatic test_contention();
        Req0 = 1; Sel0 = 5'd3; Data0 = 32'h11;
        Req1 = 1; Sel1 = 5'd4; Data1 = 32'h22;
        tick();
        checks++;
        if (!(Ack0 === 1'b1 && Ack1 === 1'b0 && WriteSelect === 5'd3 && WriteData === 32'h11)) begin
            failures++;
            $display("FAIL contention_first: got a0=%b a1=%b sel=%0d data=%h, want a0=1 a1=0 sel=3 data=11",
                     Ack0, Ack1, WriteSelect, WriteData);
        end
        Req0 = 0;
        tick();
        checks++;
        if (!(Ack0 === 1'b0 && Ack1 === 1'b1 && WriteSelect === 5'd4 && WriteData === 32'h22)) begin
            failures++;
            $display("FAIL contention_second: got a0=%b a1=%b sel=%0d data=%h, want a0=0 a1=1 sel=4 data=22",
                     Ack0, Ack1, WriteSelect, WriteData);
        end
        Req1 = 0;
        tick();
        checks++;
        if (rf[3] !== 32'h11 || rf[4] !== 32'h22 || WriteEnable !== 1'b0) begin
            failures++;
            $display("FAIL contention_regs: got r3=%h r4=%h we=%b, want r3=11 r4=22 we=0",
                     rf[3], rf[4], WriteEnable);
        end
    endtask

    task automatic test_single_write();
        Req0 = 1; Sel0 = 5'd5; Data0 = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (!(WriteEnable === 1'b1 && Ack0 === 1'b1 && Ack1 === 1'b0 &&
              WriteSelect === 5'd5 && WriteData === 32'hDEAD_BEEF)) begin
            failures++;
            $display("FAIL single_write_port: got we=%b a0=%b a1=%b sel=%0d data=%h, want 1 1 0 5 deadbeef",
                     WriteEnable, Ack0, Ack1, WriteSelect, WriteData);
        end
        Req0 = 0;
        tick();
        checks++;
        if (rf[5] !== 32'hDEAD_BEEF || WriteEnable !== 1'b0 || Ack0 !== 1'b0) begin
            failures++;
            $display("FAIL single_write_reg: got r5=%h we=%b a0=%b, want r5=deadbeef we=0 a0=0",
                     rf[5], WriteEnable, Ack0);
        end
    endtask

    task automatic test_same_destination();
        // Requester 1 wins a solo grant first so the next tie goes to 0.
        Req1 = 1; Sel1 = 5'd9; Data1 = 32'h99;
        tick();
        Req1 = 0;
        tick();
        Req0 = 1; Sel0 = 5'd7; Data0 = 32'hAAAA;
        Req1 = 1; Sel1 = 5'd7; Data1 = 32'hBBBB;
        tick();
        checks++;
        if (!(Ack0 === 1'b1 && Ack1 === 1'b0 && WriteData === 32'hAAAA)) begin
            failures++;
            $display("FAIL samedest_first: got a0=%b a1=%b data=%h, want a0=1 a1=0 data=aaaa",
                     Ack0, Ack1, WriteData);
        end
        Req0 = 0;
        tick();
        checks++;
        if (!(Ack0 === 1'b0 && Ack1 === 1'b1 && WriteData === 32'hBBBB)) begin
            failures++;
            $display("FAIL samedest_second: got a0=%b a1=%b data=%h, want a0=0 a1=1 data=bbbb",
                     Ack0, Ack1, WriteData);
        end
        Req1 = 0;
        tick();
        checks++;
        if (rf[7] !== 32'hBBBB) begin
            failures++;
            $display("FAIL samedest_reg: got r7=%h, want bbbb", rf[7]);
        end
    endtask

    task automatic test_fairness();
        int   n0 = 0, n1 = 0;
        logic prev0 = 1'bx;
        Req0 = 1; Sel0 = 5'd10; Data0 = 32'h1000;
        Req1 = 1; Sel1 = 5'd11; Data1 = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (WriteEnable !== 1'b1 || (Ack0 ^ Ack1) !== 1'b1 || (i > 0 && Ack0 === prev0)) begin
                failures++;
                $display("FAIL fairness_cycle %0d: got we=%b a0=%b a1=%b prev_a0=%b, want we=1 one ack alternating",
                         i, WriteEnable, Ack0, Ack1, prev0);
            end
            prev0 = Ack0;
            if (Ack0 === 1'b1) begin n0++; Data0 = Data0 + 1; end
            if (Ack1 === 1'b1) begin n1++; Data1 = Data1 + 1; end
        end
        checks++;
        if (n0 != 4 || n1 != 4) begin
            failures++;
            $display("FAIL fairness_counts: got n0=%0d n1=%0d, want 4 4", n0, n1);
        end
        Req0 = 0; Req1 = 0;
        tick();
        tick();
    endtask

    task automatic test_held_no_duplicate();
        int   writes = 0;
        logic [3:0] pat;
        Req1 = 1; Sel1 = 5'd12; Data1 = 32'hC0C0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat[3-i] = Ack1;
            if (WriteEnable === 1'b1) writes++;
        end
        checks++;
        if (pat !== 4'b1010 || writes != 2) begin
            failures++;
            $display("FAIL held_pattern: got ack1=%b writes=%0d, want 1010 2", pat, writes);
        end
        Req1 = 0;
        tick();
        tick();
        writes = 0;
        Req1 = 1; Data1 = 32'hC1C1;
        tick();
        if (WriteEnable === 1'b1) writes++;
        Req1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (WriteEnable === 1'b1) writes++;
        end
        checks++;
        if (writes != 1 || rf[12] !== 32'hC1C1) begin
            failures++;
            $display("FAIL held_drop_on_ack: got writes=%0d r12=%h, want 1 c1c1", writes, rf[12]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Reset = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if ({Ack0, Ack1, WriteEnable, WriteSelect, WriteData} !==
                {m_ack0, m_ack1, m_we, m_sel, m_data}) begin
                failures++;
                $display("FAIL random_cycle %0d: got a0=%b a1=%b we=%b sel=%0d data=%h, want a0=%b a1=%b we=%b sel=%0d data=%h",
                         i, Ack0, Ack1, WriteEnable, WriteSelect, WriteData,
                         m_ack0, m_ack1, m_we, m_sel, m_data);
            end
            checks++;
            if ((Ack0 & Ack1) !== 1'b0 || WriteEnable !== (Ack0 | Ack1)) begin
                failures++;
                $display("FAIL random_invariant %0d: got a0=%b a1=%b we=%b, want exclusive acks and we=a0|a1",
                         i, Ack0, Ack1, WriteEnable);
            end
            // Requesters: hold until acked; on ack, drop or present a new request.
            if (!Req0 || Ack0 === 1'b1) begin
                Req0  = $urandom_range(0, 1);
                Sel0  = SW'($urandom);
                Data0 = $urandom;
            end
            if (!Req1 || Ack1 === 1'b1) begin
                Req1  = $urandom_range(0, 1);
                Sel1  = SW'($urandom);
                Data1 = $urandom;
            end
        end
        Reset = 0; Req0 = 0; Req1 = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        m_we = 0; m_ack0 = 0; m_ack1 = 0; m_sel = '0; m_data = '0; m_last = 1;
        test_reset();
        test_contention();
        test_single_write();
        test_same_destination();
        test_fairness();
        test_held_no_duplicate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
